csa_accum_seq: RTL
==================

CSA_ACCUM_SEQ -- requirements
Module: csa_accum_seq

Interface
REQ-001 Parameter: OPW, default 4, operand width in bits.
REQ-002 Parameter: ACCW, default 8, accumulator and result width in bits; ACCW SHALL be at least OPW+4.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 Start  input  1  begin a burst; sampled only in IDLE.
REQ-006 Len  input  4  operand count for the burst, 0..15; captured with Start.
REQ-007 In_Valid  input  1  In_Data holds a valid operand.
REQ-008 In_Data  input  OPW  unsigned operand.
REQ-009 In_Ready  output  1  block accepts an operand this cycle.
REQ-010 Out_Valid  output  1  Result holds a valid value.
REQ-011 Out_Ready  input  1  consumer accepts Result.
REQ-012 Result  output  ACCW  resolved sum of the burst, modulo 2^ACCW.
REQ-013 Busy  output  1  high in every state except IDLE.
REQ-014 Remaining  output  4  operands still to be accepted in the current burst.

Function
REQ-015 The FSM SHALL have four states: IDLE, ACCUM, RESOLVE, DONE.
REQ-016 IDLE: on Start=1, capture Len into Remaining, clear the S and C registers, and go to ACCUM if Len>0, otherwise go to RESOLVE.
REQ-017 In_Ready SHALL be 1 only in ACCUM, driven from state, with no combinational path from In_Valid.
REQ-018 An operand is accepted when In_Valid and In_Ready are both 1 in the same cycle.
REQ-019 On acceptance, with X the zero-extended In_Data, the registers SHALL update to S<=S^C^X and C<=((S&C)|(S&X)|(C&X))<<1, truncated to ACCW bits.
REQ-020 On acceptance, Remaining SHALL decrement by 1.
REQ-021 The acceptance that makes Remaining 0 SHALL move the FSM to RESOLVE on the same edge.
REQ-022 In ACCUM with In_Valid=0: S, C and Remaining hold, and the state holds.
REQ-023 RESOLVE: Result<=S+C modulo 2^ACCW in exactly one cycle, then go to DONE.
REQ-024 DONE: Out_Valid=1, and Result is held stable until the handshake.
REQ-025 On Out_Valid and Out_Ready both 1, the FSM SHALL go to IDLE and Out_Valid SHALL drop the next cycle.
REQ-026 Start SHALL be ignored in ACCUM, RESOLVE and DONE, including in the DONE handshake cycle; a new burst needs Start while in IDLE.
REQ-027 Latency from the final accepted operand to Out_Valid=1 SHALL be 2 cycles: one edge into RESOLVE, one edge into DONE.
REQ-028 With Len=0, Out_Valid SHALL rise 2 cycles after Start, with Result=0.
REQ-029 Carry-out above bit ACCW-1 SHALL be discarded; there is no overflow flag, and the default 15×15 maximum of 225 fits in 8 bits.
REQ-030 Len and In_Data SHALL be ignored outside their capture and acceptance cycles.

Reset
REQ-031 With rst_n=0 at a rising edge, the next state SHALL be: state=IDLE, S=0, C=0, Remaining=0, Result=0, Out_Valid=0, In_Ready=0, Busy=0.
REQ-032 Reset SHALL take priority over every other input, in every state, mid-burst included.
REQ-033 A partially accumulated burst SHALL be discarded by reset, with no Out_Valid pulse afterwards.
REQ-034 Starting the first cycle after rst_n returns to 1, the block SHALL accept Start normally.

Verification
REQ-035 Start with Len=2, then operands 4'b1010 and 4'b0011 on consecutive cycles -> Out_Valid 2 cycles after the second acceptance, Result=13.
REQ-036 Len=3, operands 13, 7, 1 with a 2-cycle In_Valid gap after 13 -> Remaining goes 3,2,2,2,1,0 and Result=21.
REQ-037 Len=15, all operands 15 -> Result=225 with Out_Ready=1 -> Busy=0 the cycle after the handshake.
REQ-038 Result ready with Out_Ready=0 for 5 cycles, Start pulsed during DONE -> Out_Valid and Result stay stable, Start is ignored, and exit occurs only on Out_Ready=1.
REQ-039 rst_n=0 after 2 of 4 operands, then a fresh Len=1 burst with operand 9 -> Result=9, with no stale S/C contribution.
REQ-040 Len=0 Start -> In_Ready never rises, Out_Valid=1 2 cycles later, Result=0.

Source files
------------

// File: rtl/csa_accum_seq.sv
// csa_accum_seq: carry-save burst accumulator (Start/Len burst, In_* operand stream, Out_* result handshake, Busy/Remaining status)
module csa_accum_seq #(
    parameter int OPW  = 4,
    parameter int ACCW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            Start,
    input  logic [3:0]      Len,
    input  logic            In_Valid,
    input  logic [OPW-1:0]  In_Data,
    output logic            In_Ready,
    output logic            Out_Valid,
    input  logic            Out_Ready,
    output logic [ACCW-1:0] Result,
    output logic            Busy,
    output logic [3:0]      Remaining
);
    typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;
    state_t state, state_nx;
    logic [ACCW-1:0] s, c, x;
    logic accept;
    assign x = {{(ACCW-OPW){1'b0}}, In_Data};
    assign accept = (state == ACCUM) && In_Valid;
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = Start ? ((Len != 4'd0) ? ACCUM : RESOLVE) : IDLE;
            ACCUM:   state_nx = (In_Valid && Remaining == 4'd1) ? RESOLVE : ACCUM;
            RESOLVE: state_nx = DONE;
            DONE:    state_nx = Out_Ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        In_Ready  = state == ACCUM;
        Out_Valid = state == DONE;
        Busy      = state != IDLE;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s         <= '0;
            c         <= '0;
            Remaining <= '0;
            Result    <= '0;
        end else if (state == IDLE && Start) begin
            s         <= '0;
            c         <= '0;
            Remaining <= Len;
        end else if (accept) begin
            s         <= s ^ c ^ x;
            c         <= ((s & c) | (s & x) | (c & x)) << 1;
            Remaining <= Remaining - 4'd1;
        end else if (state == RESOLVE) begin
            Result    <= s + c;
        end
    end
endmodule
